// File: rtl/mhbf_cfg_sequencer_pkg.sv
// rtl/mhbf_cfg_sequencer_pkg.sv - shared state/error encodings and width helpers for the cascade config sequencer
package mhbf_cfg_sequencer_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_HDR       = 3'd1;
  localparam logic [2:0] S_SCAN      = 3'd2;
  localparam logic [2:0] S_START     = 3'd3;
  localparam logic [2:0] S_STREAM    = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;
  localparam logic [2:0] S_ERR       = 3'd7;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_EMPTY   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_RANGE   = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/mhbf_done_timer.sv
// rtl/mhbf_done_timer.sv - loadable down-counter flagging expiry of the stage done wait
module mhbf_done_timer #(
  parameter int W = 11
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // Expires on the last enabled cycle, so a load value of N allows exactly N wait cycles.
  assign o_expired = i_en && (r_cnt == W'(1));

endmodule

// File: rtl/mhbf_cfg_sequencer.sv
// rtl/mhbf_cfg_sequencer.sv - loads per-stage coefficient blocks and publishes bypass mask / active count
module mhbf_cfg_sequencer
  import mhbf_cfg_sequencer_pkg::*;
#(
  parameter int NSTAGE_MAX     = 8,
  parameter int COEFF_WIDTH    = 24,
  parameter int TAPS_PER_STAGE = 32,
  parameter int DONE_TIMEOUT   = 1024,
  localparam int AW            = clog2(NSTAGE_MAX + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cfg_start,
  input  logic [COEFF_WIDTH-1:0] i_cfg_data,
  input  logic                   i_cfg_valid,
  output logic                   o_cfg_ready,
  output logic [COEFF_WIDTH-1:0] o_stg_data,
  output logic [NSTAGE_MAX-1:0]  o_stg_valid,
  input  logic [NSTAGE_MAX-1:0]  i_stg_ready,
  output logic [NSTAGE_MAX-1:0]  o_stg_start,
  input  logic [NSTAGE_MAX-1:0]  i_stg_done,
  output logic [NSTAGE_MAX-1:0]  o_bypass,
  output logic [AW-1:0]          o_active_num,
  output logic                   o_busy,
  output logic                   o_cfg_done,
  output logic                   o_cfg_err,
  output logic [1:0]             o_err_code
);

  localparam int KW = clog2(NSTAGE_MAX + 1);
  localparam int WW = clog2(TAPS_PER_STAGE + 1);
  localparam int TW = clog2(DONE_TIMEOUT + 1);
  localparam logic [NSTAGE_MAX-1:0] STG_ONE = NSTAGE_MAX'(1);

  logic [2:0]            r_state;
  logic [NSTAGE_MAX-1:0] r_mask;
  logic [KW-1:0]         r_k;
  logic [WW-1:0]         r_wcnt;
  logic [NSTAGE_MAX-1:0] r_bypass;
  logic [AW-1:0]         r_active;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [1:0]            r_err_code;

  logic [NSTAGE_MAX-1:0] w_sel;
  logic                  w_xfer;
  logic                  w_hdr_xfer;
  logic                  w_last_word;
  logic                  w_stg_done;
  logic                  w_expired;
  logic                  w_range_err;
  logic                  w_empty;

  // One-hot selector; k == NSTAGE_MAX shifts out to zero, selecting nothing.
  assign w_sel       = STG_ONE << r_k;
  assign w_xfer      = (r_state == S_STREAM) && i_cfg_valid && |(i_stg_ready & w_sel);
  assign w_hdr_xfer  = (r_state == S_HDR) && i_cfg_valid;
  assign w_last_word = w_xfer && (r_wcnt == WW'(TAPS_PER_STAGE - 1));
  assign w_stg_done  = |(i_stg_done & w_sel);
  assign w_range_err = (i_cfg_data >> NSTAGE_MAX) != '0;
  assign w_empty     = i_cfg_data[NSTAGE_MAX-1:0] == '0;

  mhbf_done_timer #(.W(TW)) u_done_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_last_word),
    .i_load_val (TW'(DONE_TIMEOUT)),
    .i_en       (r_state == S_WAIT_DONE),
    .o_expired  (w_expired)
  );

  always_comb begin
    o_cfg_ready = 1'b0;
    o_stg_valid = '0;
    o_stg_start = '0;
    case (r_state)
      S_HDR:    o_cfg_ready = 1'b1;
      S_START:  o_stg_start = w_sel;
      S_STREAM: begin
        o_cfg_ready = |(i_stg_ready & w_sel);
        o_stg_valid = i_cfg_valid ? w_sel : '0;
      end
      default:  ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_mask     <= '0;
      r_k        <= '0;
      r_wcnt     <= '0;
      r_bypass   <= '1;
      r_active   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_cfg_start) begin
          r_state    <= S_HDR;
          r_busy     <= 1'b1;
          r_err      <= 1'b0;
          r_err_code <= ERR_NONE;
        end
        S_HDR: if (w_hdr_xfer) begin
          r_mask <= i_cfg_data[NSTAGE_MAX-1:0];
          r_k    <= '0;
          if (w_range_err) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= ERR_RANGE;
          end else if (w_empty) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= ERR_EMPTY;
          end else begin
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (r_k >= KW'(NSTAGE_MAX)) r_state <= S_FINISH;
          else if (|(r_mask & w_sel)) r_state <= S_START;
          else r_k <= r_k + KW'(1);
        end
        S_START: begin
          r_wcnt  <= '0;
          r_state <= S_STREAM;
        end
        S_STREAM: if (w_xfer) begin
          r_wcnt <= r_wcnt + WW'(1);
          if (w_last_word) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (w_stg_done) begin
            r_k     <= r_k + KW'(1);
            r_state <= S_SCAN;
          end else if (w_expired) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
          end
        end
        S_FINISH: begin
          // Bypass and active count are only ever written here, together.
          r_bypass <= ~r_mask;
          r_active <= AW'(popcount(64'(r_mask)));
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        S_ERR: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_stg_data   = i_cfg_data;
  assign o_bypass     = r_bypass;
  assign o_active_num = r_active;
  assign o_busy       = r_busy;
  assign o_cfg_done   = r_done;
  assign o_cfg_err    = r_err;
  assign o_err_code   = r_err_code;

endmodule

// File: tb/tb_mhbf_cfg_sequencer.sv
// tb/tb_mhbf_cfg_sequencer.sv - scoreboard bench for the cascade config sequencer
module tb_mhbf_cfg_sequencer;

  localparam int N    = 4;
  localparam int CW   = 24;
  localparam int TAPS = 4;
  localparam int TO   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [CW-1:0] cfg_data = '0;
  logic          cfg_ready;
  logic [CW-1:0] stg_data;
  logic [N-1:0]  stg_valid;
  logic [N-1:0]  stg_ready = '0;
  logic [N-1:0]  stg_start;
  logic [N-1:0]  stg_done = '0;
  logic [N-1:0]  bypass;
  logic [2:0]    active_num;
  logic          busy, cfg_done, cfg_err;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  mhbf_cfg_sequencer #(
    .NSTAGE_MAX(N), .COEFF_WIDTH(CW), .TAPS_PER_STAGE(TAPS), .DONE_TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_start(cfg_start), .i_cfg_data(cfg_data),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready), .o_stg_data(stg_data),
    .o_stg_valid(stg_valid), .i_stg_ready(stg_ready), .o_stg_start(stg_start),
    .i_stg_done(stg_done), .o_bypass(bypass), .o_active_num(active_num),
    .o_busy(busy), .o_cfg_done(cfg_done), .o_cfg_err(cfg_err), .o_err_code(err_code)
  );

  typedef struct { int stage; logic [CW-1:0] data; } word_t;
  typedef struct { bit is_err; logic [1:0] code; logic [N-1:0] byp; logic [2:0] act; } evt_t;

  word_t exp_words[$];
  int    exp_starts[$];
  evt_t  exp_evts[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_xfer_cyc = 0;
  int ready_mode = 0;
  logic [N-1:0] no_done = '0;
  logic [N-1:0] m_bypass = '1;
  logic [2:0]   m_active = '0;
  logic         prev_err = 1'b0;
  int           rx_cnt[N];
  int           dly[N];
  logic [N-1:0] done_lvl = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: condition not met", name);
  endtask

  // Monitor: pops expectations whenever the DUT presents a transfer, start pulse or completion.
  initial begin
    evt_t  e;
    word_t w;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_err = 1'b0;
      end else begin
        if (stg_valid != '0) begin
          if (exp_words.size() == 0) fail("valid_unexpected");
          else check("valid_sel", 32'(stg_valid), 32'(1) << exp_words[0].stage);
        end
        for (int i = 0; i < N; i++) begin
          if (stg_valid[i] && stg_ready[i]) begin
            last_xfer_cyc = cyc;
            if (exp_words.size() == 0) fail("word_unexpected");
            else begin
              w = exp_words.pop_front();
              check("word_stage", 32'(i), 32'(w.stage));
              check("word_data", 32'(stg_data), 32'(w.data));
            end
          end
          if (stg_start[i]) begin
            if (exp_starts.size() == 0) fail("start_unexpected");
            else check("start_stage", 32'(i), 32'(exp_starts.pop_front()));
          end
        end
        if (cfg_done) begin
          if (exp_evts.size() == 0) fail("done_unexpected");
          else begin
            e = exp_evts.pop_front();
            check("done_is_err", 32'(e.is_err), 32'd0);
            check("done_bypass", 32'(bypass), 32'(e.byp));
            check("done_active", 32'(active_num), 32'(e.act));
          end
        end
        if (cfg_err && !prev_err) begin
          if (exp_evts.size() == 0) fail("err_unexpected");
          else begin
            e = exp_evts.pop_front();
            check("err_is_err", 32'(e.is_err), 32'd1);
            check("err_code", 32'(err_code), 32'(e.code));
            check("err_bypass", 32'(bypass), 32'(e.byp));
            check("err_active", 32'(active_num), 32'(e.act));
            if (e.code == 2'd2) check("timeout_latency", 32'(cyc - last_xfer_cyc), 32'd17);
          end
        end
        prev_err = cfg_err;
      end
    end
  end

  // Stage responders: ready pattern per mode, done level two cycles after a full block.
  initial begin
    for (int i = 0; i < N; i++) begin rx_cnt[i] = 0; dly[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rst || stg_start[i]) begin
          rx_cnt[i] = 0; dly[i] = 0; done_lvl[i] = 1'b0;
        end else if (stg_valid[i] && stg_ready[i]) begin
          rx_cnt[i]++;
          if (rx_cnt[i] == TAPS && !no_done[i]) dly[i] = 2;
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (dly[i] > 0) begin
          dly[i]--;
          if (dly[i] == 0) done_lvl[i] = 1'b1;
        end
      end
      stg_done = done_lvl;
      case (ready_mode)
        1:       stg_ready = {3'b111, cyc[0]};
        2:       stg_ready = N'($urandom);
        default: stg_ready = '1;
      endcase
    end
  end

  task automatic check_reset_vals();
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_stg_valid", 32'(stg_valid), 32'd0);
    check("rst_stg_start", 32'(stg_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cfg_done", 32'(cfg_done), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_bypass", 32'(bypass), 32'hF);
    check("rst_active", 32'(active_num), 32'd0);
  endtask

  task automatic run_load(input logic [CW-1:0] hdr, input bit rand_valid, input bit mid_start, input int rst_at);
    logic [CW-1:0] q[$];
    logic [CW-1:0] d;
    logic [N-1:0]  m;
    int            sent;
    int            budget;
    bit            xfer;
    bit            to;
    m = hdr[N-1:0];
    sent = 0;
    to = 1'b0;
    q.push_back(hdr);
    if (hdr[CW-1:N] != '0) begin
      exp_evts.push_back('{is_err: 1'b1, code: 2'd3, byp: m_bypass, act: m_active});
    end else if (m == '0) begin
      exp_evts.push_back('{is_err: 1'b1, code: 2'd1, byp: m_bypass, act: m_active});
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m[i] && !to) begin
          exp_starts.push_back(i);
          for (int j = 0; j < TAPS; j++) begin
            d = CW'($urandom);
            q.push_back(d);
            exp_words.push_back('{stage: i, data: d});
          end
          if (no_done[i]) to = 1'b1;
        end
      end
      if (to) exp_evts.push_back('{is_err: 1'b1, code: 2'd2, byp: m_bypass, act: m_active});
      else begin
        m_bypass = ~m;
        m_active = 3'($countones(m));
        exp_evts.push_back('{is_err: 1'b0, code: 2'd0, byp: m_bypass, act: m_active});
      end
    end

    @(posedge clk); #1; cfg_start = 1'b1;
    @(posedge clk); #1; cfg_start = 1'b0;
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_cleared", 32'(cfg_err), 32'd0);
    check("code_cleared", 32'(err_code), 32'd0);
    @(posedge clk); #1;

    budget = 400;
    while (q.size() > 0 && budget > 0 && busy) begin
      cfg_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_data  = cfg_valid ? q[0] : CW'($urandom);
      cfg_start = (mid_start && sent == 2) ? 1'b1 : 1'b0;
      @(negedge clk);
      xfer = cfg_valid && cfg_ready;
      @(posedge clk); #1;
      if (xfer) begin
        void'(q.pop_front());
        sent++;
      end
      budget--;
      if (rst_at >= 0 && sent - 1 == rst_at) begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_start = 1'b0;
        exp_words.delete(); exp_starts.delete(); exp_evts.delete();
        m_bypass = '1; m_active = '0;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check_reset_vals();
        return;
      end
    end
    cfg_valid = 1'b0;
    cfg_start = 1'b0;
    if (q.size() != 0) fail("stream_incomplete");

    budget = 100;
    while (busy && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (busy) fail("busy_stuck");
    @(negedge clk);
    @(negedge clk);
    check("words_left", 32'(exp_words.size()), 32'd0);
    check("starts_left", 32'(exp_starts.size()), 32'd0);
    check("events_left", 32'(exp_evts.size()), 32'd0);
    check("hold_bypass", 32'(bypass), 32'(m_bypass));
    check("hold_active", 32'(active_num), 32'(m_active));
  endtask

  initial begin
    logic [CW-1:0] hdr;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals();

    ready_mode = 0;
    run_load(24'h00000B, 1'b0, 1'b0, -1);
    ready_mode = 1;
    run_load(24'h000001, 1'b1, 1'b0, -1);
    ready_mode = 0;
    run_load(24'h000000, 1'b0, 1'b0, -1);
    no_done = 4'b0010;
    run_load(24'h000002, 1'b0, 1'b0, -1);
    no_done = 4'b0000;
    run_load(24'h000010, 1'b0, 1'b0, -1);
    run_load(24'h00000F, 1'b0, 1'b1, -1);
    run_load(24'h000001, 1'b0, 1'b0, 2);
    run_load(24'h00000B, 1'b0, 1'b0, -1);

    ready_mode = 2;
    for (int t = 0; t < 8; t++) begin
      hdr = CW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) hdr[N + $urandom_range(0, CW - N - 1)] = 1'b1;
      no_done = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      run_load(hdr, 1'b1, 1'($urandom_range(0, 1)), -1);
    end
    no_done = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/mhbf_cfg_sequencer.md
Name: mhbf_cfg_sequencer

Overview:
Configuration sequencer for a parametrised multi-stage, multichannel half-band decimation cascade.
- Accepts one coefficient stream and a stage-enable mask.
- Delivers each enabled stage's coefficient block over a per-stage valid/ready handshake.
- Waits for each stage's done acknowledge.
- Atomically publishes the bypass mask and active-stage count consumed by the cascade data path.
- Adds runtime stage bypass, backpressure and timeout/error reporting to the cascade control path.

Parameters:
NSTAGE_MAX, 8, maximum cascade stages (1..COEFF_WIDTH).
COEFF_WIDTH, 24, config/coefficient word width.
TAPS_PER_STAGE, 32, coefficient words per stage block.
DONE_TIMEOUT, 1024, max cycles waiting for Stg_Done before error.

Ports:
CLK  in  1  clock.
RST  in  1  synchronous active-high reset.
Cfg_Start  in  1  single-cycle pulse; begins a load.
Cfg_Data  in  COEFF_WIDTH  config stream word.
Cfg_Valid  in  1  stream word valid.
Cfg_Ready  out  1  stream word accepted when Valid&&Ready.
Stg_Data  out  COEFF_WIDTH  shared word bus to all stages.
Stg_Valid  out  NSTAGE_MAX  one-hot valid to the selected stage.
Stg_Ready  in  NSTAGE_MAX  per-stage ready.
Stg_Start  out  NSTAGE_MAX  one-hot one-cycle pulse opening a stage load.
Stg_Done  in  NSTAGE_MAX  per-stage load-complete level.
Bypass  out  NSTAGE_MAX  1 = stage bypassed in data path.
Active_Num  out  clog2(NSTAGE_MAX+1)  popcount of enabled stages.
Busy  out  1  load in progress.
Cfg_Done  out  1  one-cycle pulse on successful load.
Cfg_Err  out  1  sticky error flag.
Err_Code  out  2  0 none, 1 empty mask, 2 done timeout, 3 mask bits above NSTAGE_MAX.

Behaviour:
- Reset (RST=1 at a CLK edge) values:
  - Bypass = all ones; Active_Num = 0.
  - Busy, Cfg_Done, Cfg_Err, Cfg_Ready, Stg_Valid, Stg_Start = 0; Err_Code = 0.
  - FSM -> IDLE.
  - Reset mid-load aborts immediately; no further Stg_Start or Stg_Valid after reset.
- FSM states: IDLE, HDR, SCAN, START, STREAM, WAIT_DONE, FINISH, ERR.
- IDLE:
  - Cfg_Start -> HDR; Busy = 1 from the next cycle.
  - Cfg_Err and Err_Code are cleared on entry to HDR.
- HDR:
  - Cfg_Ready = 1; on transfer, latch mask = Cfg_Data[NSTAGE_MAX-1:0].
  - mask == 0 -> ERR, code 1.
  - Any Cfg_Data bit above NSTAGE_MAX-1 set -> ERR, code 3 (code 3 has priority over code 1).
  - Otherwise stage pointer k = 0 and go to SCAN.
- SCAN:
  - One cycle per index examined.
  - If mask[k] = 1 -> START; else k++.
  - k past NSTAGE_MAX-1 -> FINISH.
- START: Stg_Start[k] = 1 for exactly one cycle; word counter cleared; -> STREAM.
- STREAM:
  - Combinational pass-through: Stg_Data = Cfg_Data, Stg_Valid[k] = Cfg_Valid, Cfg_Ready = Stg_Ready[k].
  - All other Stg_Valid bits are 0.
  - Count transfers only when Cfg_Valid && Stg_Ready[k]; no word is dropped or duplicated under any stall pattern.
  - After TAPS_PER_STAGE transfers -> WAIT_DONE.
- WAIT_DONE:
  - Cfg_Ready = 0; timeout counter runs.
  - Stg_Done[k] = 1 -> k++, SCAN.
  - Counter reaching DONE_TIMEOUT with no done -> ERR, code 2.
  - Stg_Done on a non-selected stage is ignored.
- FINISH (1 cycle):
  - Register Bypass = ~mask and Active_Num = popcount(mask) simultaneously.
  - Cfg_Done pulse; Busy = 0; -> IDLE.
  - Bypass and Active_Num never change at any other time, so a failed load leaves the previous values intact.
- ERR:
  - Cfg_Err = 1; Busy = 0; -> IDLE (one cycle).
  - Cfg_Err stays sticky until the next Cfg_Start.
- Cfg_Start while Busy = 1 is ignored.
- Cfg_Start in the same cycle as FINISH is ignored.
- Latency: load cycles = 1 + NSTAGE_MAX scan + per enabled stage (1 + TAPS_PER_STAGE + done wait), assuming no stalls.

Decomposition:
- Shared package holds:
  - FSM state encoding constants.
  - Err_Code constants ERR_NONE/ERR_EMPTY/ERR_TIMEOUT/ERR_RANGE.
  - Width functions clog2 and popcount.
- Natural sub-module: mhbf_done_timer (loadable down-counter with expiry flag), used in WAIT_DONE.

Test Plan:
All scenarios use NSTAGE_MAX=4, TAPS_PER_STAGE=4, DONE_TIMEOUT=16.
1. Full load: mask 4'b1011, 12 data words, stages assert done 2 cycles after their last word -> Stg_Start pulses on stages 0, 1, 3 in order; stage 2 never receives valid; Cfg_Done pulses once; Bypass = 4'b0100; Active_Num = 3.
2. Backpressure: mask 4'b0001, Stg_Ready[0] toggling 1010..., Cfg_Valid random -> exactly 4 words delivered in order, matching the stream.
3. Empty mask: header 0 -> Cfg_Err = 1, Err_Code = 1; Bypass and Active_Num unchanged from the prior load.
4. Timeout: mask 4'b0010, stage 1 never asserts done -> Cfg_Err with Err_Code = 2 exactly 16 cycles after WAIT_DONE entry; no Cfg_Done; the next Cfg_Start clears Cfg_Err.
5. Range error: header 24'h000010 -> Err_Code = 3. Also: Cfg_Start pulsed mid-load is ignored, with word count unaffected.
6. Reset mid-STREAM at word 2 of stage 0 -> next cycle all outputs equal their reset values, Bypass = 4'b1111, FSM idle; a subsequent full load succeeds.
